axi4_mmio_console: RTL and testbench
====================================

AXI4_MMIO_CONSOLE -- requirements
Module: axi4_mmio_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16; console byte FIFO depth, a power of two, minimum 2.
REQ-002 SHALL have parameter PASS_MAGIC, default 32'd123456789; write value that sets tests_passed.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports s_awvalid in 1, s_awready out 1, s_awaddr in 32, s_awprot in 3  write-address channel (awprot ignored).
REQ-006 SHALL have ports s_wvalid in 1, s_wready out 1, s_wdata in 32, s_wstrb in 4  write-data channel.
REQ-007 SHALL have ports s_bvalid out 1, s_bready in 1  write response; no bresp.
REQ-008 SHALL have ports s_arvalid in 1, s_arready out 1, s_araddr in 32, s_arprot in 3  read-address channel (arprot ignored).
REQ-009 SHALL have ports s_rvalid out 1, s_rready in 1, s_rdata out 32  read data; no rresp.
REQ-010 SHALL have ports tx_valid out 1, tx_ready in 1, tx_data out 8  console byte stream.
REQ-011 SHALL have port tests_passed  output  1  sticky pass flag.
REQ-012 SHALL have port bad_access  output  1  one-cycle pulse on unmapped access.

Function
REQ-013 SHALL decode full 32-bit addresses: CONSOLE 0x1000_0000, PASS 0x2000_0000; all others unmapped.
REQ-014 SHALL drive s_awready = !aw_latched && !s_bvalid and s_wready = !w_latched && !s_bvalid; AW and W accepted independently, either order.
REQ-015 SHALL commit a write on the edge where aw_latched && w_latched && !s_bvalid and the target is not blocked; commit clears both latches and sets s_bvalid.
REQ-016 SHALL, with AW and W handshaken in cycle N and target not blocked, assert s_bvalid in cycle N+2.
REQ-017 SHALL hold s_bvalid until s_bvalid && s_bready, then clear it on that edge.
REQ-018 SHALL, for CONSOLE writes with s_wstrb[0]=1, push s_wdata[7:0]; s_wstrb[0]=0 completes without push.
REQ-019 SHALL block CONSOLE commit while FIFO count == FIFO_DEPTH at cycle start (backpressure via withheld s_bvalid); a same-cycle pop does not unblock until the next cycle.
REQ-020 SHALL set tests_passed when a PASS write with s_wstrb==4'b1111 carries PASS_MAGIC; other values leave it unchanged; flag cleared only by reset.
REQ-021 SHALL complete unmapped writes normally without side effect and pulse bad_access for one cycle at commit.
REQ-022 SHALL drive s_arready = !s_rvalid; on AR handshake in cycle N, s_rvalid and s_rdata valid in cycle N+1, held stable until s_rready.
REQ-023 SHALL return read data: CONSOLE = zero-extended FIFO count; PASS = {31'b0, tests_passed}; unmapped = 32'hDEAD_BEEF with bad_access pulse at the AR handshake.
REQ-024 SHALL drive tx_valid = FIFO non-empty, tx_data = FIFO head; pop on tx_valid && tx_ready.
REQ-025 SHALL keep count unchanged on simultaneous push and pop (non-full FIFO); pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-026 SHALL process read and write channels concurrently, without mutual ordering.

Reset
REQ-027 SHALL, while resetn=0, force s_awready, s_wready, s_arready to 0 and s_bvalid, s_rvalid, tx_valid, tests_passed, bad_access to 0, s_rdata to 0.
REQ-028 SHALL on reset empty the FIFO, clear pointers, and discard latched AW/W/AR transactions with no response issued.
REQ-029 SHALL assert ready outputs per REQ-014/022 from the first cycle after resetn rises.

Structure
REQ-030 SHALL place CONSOLE/PASS addresses, PASS_MAGIC default and unmapped read value 32'hDEAD_BEEF in shared package mmio_pkg.
REQ-031 SHALL implement the FIFO as sub-module sync_fifo (parameter DEPTH, WIDTH; push/pop/full/empty/count).

Verification
REQ-032 Write 0x41 to 0x1000_0000 (AW, W same cycle), tx_ready=1 -> s_bvalid in cycle N+2; tx_valid with tx_data=0x41 one cycle after commit.
REQ-033 W in cycle 3, AW in cycle 6 to 0x2000_0000, data 123456789 -> single B response; tests_passed=1 and stays 1; later write 0 leaves it 1.
REQ-034 tx_ready=0, 17 CONSOLE writes (FIFO_DEPTH=16) -> 16 B responses, 17th s_bvalid withheld; raise tx_ready -> 17th completes, bytes drained in order.
REQ-035 Read 0x1000_0000 holding 5 bytes, s_rready low 3 cycles -> s_rvalid cycle N+1, s_rdata=5 held stable until accepted.
REQ-036 Read 0x3000_0000 and write 0x3000_0004 -> s_rdata=0xDEAD_BEEF, B completes, bad_access pulses twice, FIFO/flag unchanged.
REQ-037 resetn low with AW latched and FIFO holding 3 bytes -> no s_bvalid, tx_valid=0, count read after reset =0.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared address map, magic value and decode helper for the MMIO console
package mmio_pkg;

    localparam logic [31:0] CONSOLE_ADDR       = 32'h1000_0000;
    localparam logic [31:0] PASS_ADDR          = 32'h2000_0000;
    localparam logic [31:0] PASS_MAGIC_DEFAULT = 32'd123456789;
    localparam logic [31:0] UNMAPPED_RDATA     = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {TGT_NONE, TGT_CONSOLE, TGT_PASS} target_e;

    // Full 32-bit match; anything else is unmapped
    function automatic target_e decode(input logic [31:0] addr);
        return addr == CONSOLE_ADDR ? TGT_CONSOLE : addr == PASS_ADDR ? TGT_PASS : TGT_NONE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push on full and pop on empty are ignored
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;

    assign full   = r_count == CW'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/axi4_mmio_console.sv
// axi4_mmio_console: AXI4 MMIO sink with a console byte FIFO, a sticky pass flag and unmapped-access reporting
module axi4_mmio_console
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awprot,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arprot,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tests_passed,
    output logic        bad_access
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r_aw_lat, r_w_lat, r_bvalid, r_rvalid, r_pass;
    logic [31:0]   r_awaddr, r_wdata, r_rdata;
    logic [3:0]    r_wstrb;
    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_push, w_pop;
    logic          w_full, w_empty, w_unused;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    target_e       w_wtgt, w_rtgt;

    assign w_wtgt   = decode(r_awaddr);
    assign w_rtgt   = decode(s_araddr);
    assign w_aw_hs  = s_awvalid && s_awready;
    assign w_w_hs   = s_wvalid && s_wready;
    assign w_ar_hs  = s_arvalid && s_arready;
    // Full is the registered occupancy, so a pop in the same cycle unblocks only on the next one
    assign w_commit = resetn && r_aw_lat && r_w_lat && !r_bvalid && !(w_wtgt == TGT_CONSOLE && w_full);
    assign w_push   = w_commit && w_wtgt == TGT_CONSOLE && r_wstrb[0];
    assign w_pop    = tx_valid && tx_ready;
    assign w_unused = ^{s_awprot, s_arprot};

    assign s_awready    = resetn && !r_aw_lat && !r_bvalid;
    assign s_wready     = resetn && !r_w_lat && !r_bvalid;
    assign s_arready    = resetn && !r_rvalid;
    assign s_bvalid     = resetn && r_bvalid;
    assign s_rvalid     = resetn && r_rvalid;
    assign s_rdata      = resetn ? r_rdata : '0;
    assign tx_valid     = resetn && !w_empty;
    assign tx_data      = w_head;
    assign tests_passed = resetn && r_pass;
    assign bad_access   = (w_commit && w_wtgt == TGT_NONE) || (w_ar_hs && w_rtgt == TGT_NONE);

    // Write path: AW and W latch independently, commit when both present, B held until accepted
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_lat <= 1'b0;
            r_w_lat  <= 1'b0;
            r_bvalid <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_lat <= 1'b1;
                r_awaddr <= s_awaddr;
            end else if (w_commit) r_aw_lat <= 1'b0;
            if (w_w_hs) begin
                r_w_lat <= 1'b1;
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end else if (w_commit) r_w_lat <= 1'b0;
            if (w_commit) r_bvalid <= 1'b1;
            else if (s_bready) r_bvalid <= 1'b0;
        end
    end

    // Sticky pass flag: only a full-word write of the magic value sets it
    always_ff @(posedge clk) begin
        if (!resetn) r_pass <= 1'b0;
        else if (w_commit && w_wtgt == TGT_PASS && r_wstrb == 4'hF && r_wdata == PASS_MAGIC) r_pass <= 1'b1;
    end

    // Read path: data captured at the AR handshake and held until accepted
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rtgt == TGT_CONSOLE ? 32'(w_count) :
                        w_rtgt == TGT_PASS    ? {31'b0, r_pass} : UNMAPPED_RDATA;
        end else if (s_rready) r_rvalid <= 1'b0;
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .din    (r_wdata[7:0]),
        .pop    (w_pop),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

endmodule

// File: tb/tb_axi4_mmio_console.sv
// tb_axi4_mmio_console: directed scenarios plus randomized traffic checked cycle by cycle against a queue-based model
module tb_axi4_mmio_console;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CONS  = 32'h1000_0000;
    localparam logic [31:0] PASS  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;

    logic        clk = 0, resetn = 0;
    logic        s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 1, s_rready = 1, tx_ready = 1;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
    logic [3:0]  s_wstrb = 0;
    logic [2:0]  s_awprot = 0, s_arprot = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, tx_valid, tests_passed, bad_access;
    logic [31:0] s_rdata;
    logic [7:0]  tx_data;

    int n_tests = 0, n_fail = 0;

    bit          m_aw, m_w, m_b, m_r, m_pass;
    logic [31:0] m_awaddr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [7:0]  m_q[$];
    logic [7:0]  popped[$];
    int          b_seen = 0, bad_seen = 0;

    always #5 clk = ~clk;

    axi4_mmio_console #(.FIFO_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
        .clk(clk), .resetn(resetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tests_passed(tests_passed), .bad_access(bad_access)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        int k = $urandom_range(0, 5);
        return k < 3 ? CONS : k == 3 ? PASS : k == 4 ? 32'h3000_0000 : 32'($urandom);
    endfunction

    // Behavioural model: pending AW/W, pending responses, byte queue, flag; checked every cycle
    task automatic monitor();
        bit cons, pas, commit, ebad, awhs, whs, arhs, pop, push;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                check("reset_ctl", 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, tx_valid, tests_passed, bad_access}), 0);
                check("reset_rdata", s_rdata, 0);
                m_aw = 0; m_w = 0; m_b = 0; m_r = 0; m_pass = 0;
                m_q.delete();
            end else begin
                cons   = m_awaddr == CONS;
                pas    = m_awaddr == PASS;
                commit = m_aw && m_w && !m_b && !(cons && m_q.size() == DEPTH);
                awhs   = s_awvalid && !m_aw && !m_b;
                whs    = s_wvalid && !m_w && !m_b;
                arhs   = s_arvalid && !m_r;
                ebad   = (commit && !cons && !pas) || (arhs && s_araddr != CONS && s_araddr != PASS);
                check("awready", 32'(s_awready), 32'(!m_aw && !m_b));
                check("wready", 32'(s_wready), 32'(!m_w && !m_b));
                check("arready", 32'(s_arready), 32'(!m_r));
                check("bvalid", 32'(s_bvalid), 32'(m_b));
                check("rvalid", 32'(s_rvalid), 32'(m_r));
                if (m_r) check("rdata", s_rdata, m_rdata);
                check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
                check("tests_passed", 32'(tests_passed), 32'(m_pass));
                check("bad_access", 32'(bad_access), 32'(ebad));
                if (s_bvalid && s_bready) b_seen++;
                if (bad_access) bad_seen++;
                if (tx_valid && tx_ready) popped.push_back(tx_data);
                pop  = m_q.size() != 0 && tx_ready;
                push = commit && cons && m_wstrb[0];
                if (arhs) begin
                    m_r = 1;
                    m_rdata = s_araddr == CONS ? 32'(m_q.size()) : s_araddr == PASS ? {31'b0, m_pass} : 32'hDEAD_BEEF;
                end else if (m_r && s_rready) m_r = 0;
                if (commit && pas && m_wstrb == 4'hF && m_wdata == MAGIC) m_pass = 1;
                if (m_b && s_bready) m_b = 0;
                if (commit) begin m_b = 1; m_aw = 0; m_w = 0; end
                if (awhs) begin m_aw = 1; m_awaddr = s_awaddr; end
                if (whs) begin m_w = 1; m_wdata = s_wdata; m_wstrb = s_wstrb; end
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(m_wdata[7:0]);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        bit ad = 0, wd = 0;
        @(negedge clk);
        s_awvalid = 1; s_awaddr = a; s_wvalid = 1; s_wdata = d; s_wstrb = st;
        for (int i = 0; i < 50 && !(ad && wd); i++) begin
            #2;
            if (s_awready) ad = 1;
            if (s_wready) wd = 1;
            @(negedge clk);
            if (ad) s_awvalid = 0;
            if (wd) s_wvalid = 0;
        end
        check("wr_handshake", 32'(ad && wd), 1);
    endtask

    task automatic rd(input logic [31:0] a, input int hold, input logic [31:0] exp);
        bit ok = 0;
        @(negedge clk);
        s_arvalid = 1; s_araddr = a; s_rready = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            #2;
            ok = s_arready;
            @(negedge clk);
        end
        s_arvalid = 0;
        s_rready = (hold == 0);
        #2;
        check("rd_handshake", 32'(ok), 1);
        check("rd_valid_n1", 32'(s_rvalid), 1);
        check("rd_data", s_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            s_rready = (i == hold - 1);
            #2;
            check("rd_valid_hold", 32'(s_rvalid), 1);
            check("rd_data_hold", s_rdata, exp);
        end
        @(negedge clk);
        #2;
        check("rd_done", 32'(s_rvalid), 0);
    endtask

    initial begin
        int b0, bd0, p0;
        bit awhs = 0, whs = 0, arhs = 0;
        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL global_timeout: run did not reach the end");
                $fatal(1);
            end
        join_none
        repeat (3) @(negedge clk);
        resetn = 1;
        // Console write with AW and W together, B at N+2, byte visible right after commit
        wr(CONS, 32'h41, 4'hF);
        #2;
        check("b_not_at_n1", 32'(s_bvalid), 0);
        @(negedge clk);
        #2;
        check("b_at_n2", 32'(s_bvalid), 1);
        check("tx_valid_after_commit", 32'(tx_valid), 1);
        check("tx_data_first", 32'(tx_data), 32'h41);
        check("pass_before", 32'(tests_passed), 0);
        // W first, AW three cycles later, to the pass register
        @(negedge clk);
        s_wvalid = 1; s_wdata = MAGIC; s_wstrb = 4'hF;
        #2;
        check("w_alone_ready", 32'(s_wready), 1);
        @(negedge clk);
        s_wvalid = 0;
        repeat (2) @(negedge clk);
        b0 = b_seen;
        s_awvalid = 1; s_awaddr = PASS;
        @(negedge clk);
        s_awvalid = 0;
        repeat (4) @(negedge clk);
        #2;
        check("split_write_single_b", 32'(b_seen - b0), 1);
        check("pass_set", 32'(tests_passed), 1);
        wr(PASS, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        #2;
        check("pass_sticky", 32'(tests_passed), 1);
        // Backpressure: 17 writes into a 16-deep FIFO with the sink stalled
        @(negedge clk);
        tx_ready = 0;
        b0 = b_seen;
        p0 = popped.size();
        for (int i = 0; i < 17; i++) wr(CONS, 32'h30 + 32'(i), 4'hF);
        repeat (5) @(negedge clk);
        #2;
        check("full_b_count", 32'(b_seen - b0), 16);
        check("full_b_withheld", 32'(s_bvalid), 0);
        @(negedge clk);
        tx_ready = 1;
        for (int i = 0; i < 20 && !s_bvalid; i++) begin
            @(negedge clk);
            #2;
        end
        check("blocked_write_completes", 32'(s_bvalid), 1);
        repeat (25) @(negedge clk);
        #2;
        check("full_b_total", 32'(b_seen - b0), 17);
        check("drain_count", 32'(popped.size() - p0), 17);
        for (int i = 0; i < 17 && p0 + i < popped.size(); i++) check("drain_order", 32'(popped[p0+i]), 32'h30 + 32'(i));
        // Count read with a stalled read-data channel; strobe without byte 0 pushes nothing
        @(negedge clk);
        tx_ready = 0;
        for (int i = 0; i < 5; i++) wr(CONS, 32'hA0 + 32'(i), 4'hF);
        wr(CONS, 32'h55, 4'b1110);
        repeat (3) @(negedge clk);
        rd(CONS, 3, 32'd5);
        @(negedge clk);
        tx_ready = 1;
        repeat (10) @(negedge clk);
        // Unmapped read and write
        bd0 = bad_seen;
        b0 = b_seen;
        rd(32'h3000_0000, 0, 32'hDEAD_BEEF);
        wr(32'h3000_0004, 32'h42, 4'hF);
        repeat (4) @(negedge clk);
        #2;
        check("bad_pulses", 32'(bad_seen - bd0), 2);
        check("unmapped_b", 32'(b_seen - b0), 1);
        check("unmapped_flag_kept", 32'(tests_passed), 1);
        check("unmapped_no_push", 32'(tx_valid), 0);
        rd(CONS, 0, 32'd0);
        // Reset with AW latched and three bytes queued
        @(negedge clk);
        tx_ready = 0;
        for (int i = 0; i < 3; i++) wr(CONS, 32'h60 + 32'(i), 4'hF);
        repeat (3) @(negedge clk);
        s_awvalid = 1; s_awaddr = CONS;
        @(negedge clk);
        s_awvalid = 0;
        resetn = 0;
        repeat (2) begin
            @(negedge clk);
            #2;
            check("reset_no_b", 32'(s_bvalid), 0);
            check("reset_no_tx", 32'(tx_valid), 0);
        end
        @(negedge clk);
        resetn = 1;
        tx_ready = 1;
        repeat (3) begin
            #2;
            check("no_b_after_reset", 32'(s_bvalid), 0);
            @(negedge clk);
        end
        rd(CONS, 0, 32'd0);
        check("flag_cleared_by_reset", 32'(tests_passed), 0);
        // Randomized traffic with alternating free-running and stalled console sink
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!s_awvalid || awhs) begin s_awvalid = $urandom_range(0, 2) == 0; s_awaddr = rnd_addr(); end
            if (!s_wvalid || whs) begin
                s_wvalid = $urandom_range(0, 2) == 0;
                s_wdata  = $urandom_range(0, 5) == 0 ? MAGIC : $urandom;
                s_wstrb  = $urandom_range(0, 2) != 0 ? 4'hF : 4'($urandom);
            end
            if (!s_arvalid || arhs) begin s_arvalid = $urandom_range(0, 3) == 0; s_araddr = rnd_addr(); end
            s_bready = $urandom_range(0, 3) != 0;
            s_rready = $urandom_range(0, 3) != 0;
            tx_ready = ((c / 400) % 2 == 0) ? $urandom_range(0, 9) < 8 : 1'b0;
            #2;
            awhs = s_awvalid && s_awready;
            whs  = s_wvalid && s_wready;
            arhs = s_arvalid && s_arready;
        end
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        s_bready = 1; s_rready = 1; tx_ready = 1;
        repeat (40) @(negedge clk);
        #2;
        check("final_drained", 32'(tx_valid), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
